// File: rtl/strided_window_reader_pkg.sv
// Shared definitions for the strided window reader: shape word layout, defaults, FSM states.
package strided_window_reader_pkg;

  localparam int unsigned C_LSB = 20;
  localparam int unsigned C_W   = 12;
  localparam int unsigned H_LSB = 10;
  localparam int unsigned H_W   = 10;
  localparam int unsigned W_LSB = 0;
  localparam int unsigned W_W   = 10;

  localparam int unsigned PROD_W          = C_W + H_W;
  localparam int unsigned C_SHIFT_DEFAULT = 2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2
  } swr_state_e;

  // Words per pass: (channel words per pixel) * rows.
  function automatic logic [PROD_W-1:0] shape_len(input logic [C_W-1:0] c,
                                                 input logic [H_W-1:0] h,
                                                 input int unsigned    c_shift);
    return PROD_W'(c >> c_shift) * PROD_W'(h);
  endfunction

endpackage

// File: rtl/strided_window_reader_if.sv
// Control, bank-read and output-stream signals of the strided window reader.
interface strided_window_reader_if #(
  parameter int unsigned N_BUF_X    = 5,
  parameter int unsigned B_BUF_ADDR = 9,
  parameter int unsigned B_SHAPE    = 32,
  parameter int unsigned DATA_WIDTH = 64
) ();

  logic [B_SHAPE-1:0]             shape;
  logic                           start;
  logic                           clr;
  logic [B_BUF_ADDR*N_BUF_X-1:0]  rdaddr;
  logic [DATA_WIDTH*N_BUF_X-1:0]  rddata;
  logic                           m_valid;
  logic                           m_ready;
  logic [DATA_WIDTH*N_BUF_X-1:0]  m_data;
  logic                           m_last;
  logic                           busy;
  logic                           done;

  modport master (
    input  shape, start, clr, rddata, m_ready,
    output rdaddr, m_valid, m_data, m_last, busy, done
  );

  modport slave (
    output shape, start, clr, rddata, m_ready,
    input  rdaddr, m_valid, m_data, m_last, busy, done
  );

endinterface

// File: rtl/strided_window_reader_stream_fifo.sv
// First-word-fall-through skid FIFO with synchronous flush; DEPTH must be a power of 2.
module stream_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 321
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     valid,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_q, rd_q;
  logic [CNT_W-1:0] cnt_q;
  logic             do_push, do_pop;

  assign do_pop  = pop  & (cnt_q != '0);
  assign do_push = push & (cnt_q != CNT_W'(DEPTH));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (flush) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= din;
        wr_q        <= wr_q + PTR_W'(1);
      end
      if (do_pop) rd_q <= rd_q + PTR_W'(1);
      cnt_q <= cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  assign dout  = mem_q[rd_q];
  assign valid = (cnt_q != '0);
  assign count = cnt_q;

endmodule

// File: rtl/strided_window_reader.sv
// Issues per-bank window reads, rotates returned columns so lane 0 is the oldest,
// and streams them through a credit-limited skid FIFO.
module strided_window_reader
  import strided_window_reader_pkg::*;
#(
  parameter int unsigned N_BUF_X    = 5,
  parameter int unsigned B_BUF_ADDR = 9,
  parameter int unsigned B_SHAPE    = 32,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned C_SHIFT    = C_SHIFT_DEFAULT,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rstn,
  strided_window_reader_if.master bus
);

  localparam int unsigned ROW_W = DATA_WIDTH * N_BUF_X;
  localparam int unsigned ROT_W = (N_BUF_X > 1) ? $clog2(N_BUF_X) : 1;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned AW    = B_BUF_ADDR;

  swr_state_e              state_q, state_d;
  logic [ROT_W-1:0]        rot_q, rot_d, rot_inc;
  logic [AW-1:0]           base_q [N_BUF_X];
  logic [AW-1:0]           base_d [N_BUF_X];
  logic [AW-1:0]           ofs_q, ofs_d, len_q, len_d, len_new;
  logic [AW*N_BUF_X-1:0]   rdaddr_q, rdaddr_d;
  logic                    issue_v_q, issue_v_d, issue_last_q, issue_last_d;
  logic                    rd_v_q, rd_v_d, rd_last_q, rd_last_d;
  logic                    busy_q, busy_d, done_q, done_d;

  logic [ROW_W-1:0]        rot_data;
  logic [ROW_W:0]          fifo_dout;
  logic                    fifo_valid;
  logic [CNT_W-1:0]        fifo_count, inflight;
  logic                    credit_ok, last_pop, start_ok, is_last_ofs;
  int unsigned             src;

  assign len_new     = AW'(shape_len(bus.shape[C_LSB +: C_W], bus.shape[H_LSB +: H_W], C_SHIFT));
  assign rot_inc     = (rot_q == ROT_W'(N_BUF_X - 1)) ? '0 : rot_q + ROT_W'(1);
  assign inflight    = CNT_W'(issue_v_q) + CNT_W'(rd_v_q);
  assign credit_ok   = (fifo_count + inflight) < CNT_W'(FIFO_DEPTH);
  assign last_pop    = fifo_valid & bus.m_ready & fifo_dout[ROW_W];
  assign start_ok    = bus.start & ~busy_q & ~done_q;
  assign is_last_ofs = (ofs_q == len_q - AW'(1));

  // Barrel mux: lane k takes bank (rot + k) mod N_BUF_X.
  always_comb begin
    rot_data = '0;
    src      = 0;
    for (int unsigned k = 0; k < N_BUF_X; k++) begin
      src = (32'(rot_q) + k) % N_BUF_X;
      rot_data[k*DATA_WIDTH +: DATA_WIDTH] = bus.rddata[src*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_comb begin
    state_d      = state_q;
    rot_d        = rot_q;
    base_d       = base_q;
    ofs_d        = ofs_q;
    len_d        = len_q;
    rdaddr_d     = rdaddr_q;
    issue_v_d    = 1'b0;
    issue_last_d = 1'b0;
    rd_v_d       = issue_v_q;
    rd_last_d    = issue_last_q;
    busy_d       = busy_q;
    done_d       = 1'b0;

    if (bus.clr) begin
      state_d   = S_IDLE;
      rot_d     = '0;
      for (int unsigned i = 0; i < N_BUF_X; i++) base_d[i] = '0;
      ofs_d     = '0;
      rdaddr_d  = '0;
      rd_v_d    = 1'b0;
      rd_last_d = 1'b0;
      busy_d    = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start_ok) begin
            len_d = len_new;
            ofs_d = '0;
            if (len_new == '0) begin
              done_d = 1'b1;
              rot_d  = rot_inc;
            end else begin
              // Offset 0 goes out on the accepting edge to save a cycle of latency.
              busy_d       = 1'b1;
              for (int unsigned i = 0; i < N_BUF_X; i++) rdaddr_d[i*AW +: AW] = base_q[i];
              issue_v_d    = 1'b1;
              issue_last_d = (len_new == AW'(1));
              ofs_d        = AW'(1);
              state_d      = (len_new == AW'(1)) ? S_DRAIN : S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          if (credit_ok) begin
            for (int unsigned i = 0; i < N_BUF_X; i++) rdaddr_d[i*AW +: AW] = base_q[i] + ofs_q;
            issue_v_d    = 1'b1;
            issue_last_d = is_last_ofs;
            ofs_d        = ofs_q + AW'(1);
            if (is_last_ofs) state_d = S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (last_pop) begin
            state_d        = S_IDLE;
            busy_d         = 1'b0;
            done_d         = 1'b1;
            base_d[rot_q]  = base_q[rot_q] + len_q;
            rot_d          = rot_inc;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= S_IDLE;
      rot_q        <= '0;
      for (int unsigned i = 0; i < N_BUF_X; i++) base_q[i] <= '0;
      ofs_q        <= '0;
      len_q        <= '0;
      rdaddr_q     <= '0;
      issue_v_q    <= 1'b0;
      issue_last_q <= 1'b0;
      rd_v_q       <= 1'b0;
      rd_last_q    <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      rot_q        <= rot_d;
      base_q       <= base_d;
      ofs_q        <= ofs_d;
      len_q        <= len_d;
      rdaddr_q     <= rdaddr_d;
      issue_v_q    <= issue_v_d;
      issue_last_q <= issue_last_d;
      rd_v_q       <= rd_v_d;
      rd_last_q    <= rd_last_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  stream_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ROW_W + 1)
  ) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .flush (bus.clr),
    .push  (rd_v_q),
    .din   ({rd_last_q, rot_data}),
    .pop   (bus.m_ready),
    .dout  (fifo_dout),
    .valid (fifo_valid),
    .count (fifo_count)
  );

  assign bus.rdaddr  = rdaddr_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.m_valid = fifo_valid;
  assign bus.m_data  = fifo_dout[ROW_W-1:0];
  assign bus.m_last  = fifo_dout[ROW_W];

endmodule

// File: tb/tb_strided_window_reader.sv
// Self-checking bench: BRAM model plus a window-pass reference model of bases and rotation.
module tb_strided_window_reader;

  localparam int N     = 5;
  localparam int AW    = 9;
  localparam int DW    = 64;
  localparam int ROW_W = N * DW;

  logic clk = 1'b0;
  logic rstn;
  int   n_checks, n_fail;

  strided_window_reader_if #(.N_BUF_X(N), .B_BUF_ADDR(AW), .B_SHAPE(32), .DATA_WIDTH(DW)) bus ();

  strided_window_reader #(
    .N_BUF_X(N), .B_BUF_ADDR(AW), .B_SHAPE(32), .DATA_WIDTH(DW), .C_SHIFT(2), .FIFO_DEPTH(4)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] bram_word(input int b, input int a);
    return {16'(b), 16'(a), 32'(a * 31 + b * 7 + 32'h1357_9bdf)};
  endfunction

  // One-cycle-latency bank memories.
  always @(posedge clk)
    for (int b = 0; b < N; b++)
      bus.rddata[b*DW +: DW] <= bram_word(b, int'(bus.rdaddr[b*AW +: AW]));

  // Reference model: per-bank base and rotation, advanced once per completed pass.
  int m_rot;
  int m_base [N];

  function automatic void model_reset();
    m_rot = 0;
    for (int b = 0; b < N; b++) m_base[b] = 0;
  endfunction

  function automatic void model_advance(input int len);
    m_base[m_rot] = (m_base[m_rot] + len) % 512;
    m_rot         = (m_rot + 1) % N;
  endfunction

  function automatic int model_len(input int c, input int h);
    return ((c >> 2) * h) % 512;
  endfunction

  function automatic logic [ROW_W-1:0] exp_row(input int k);
    logic [ROW_W-1:0] r;
    int b;
    for (int j = 0; j < N; j++) begin
      b = (m_rot + j) % N;
      r[j*DW +: DW] = bram_word(b, (m_base[b] + k) % 512);
    end
    return r;
  endfunction

  function automatic logic [AW*N-1:0] exp_addr(input int k);
    logic [AW*N-1:0] v;
    for (int b = 0; b < N; b++) v[b*AW +: AW] = AW'((m_base[b] + k) % 512);
    return v;
  endfunction

  logic [ROW_W-1:0]  got_data [$];
  bit                got_last [$];
  logic [AW*N-1:0]   got_addr [$];
  int                done_cnt, first_valid, max_cnt;
  bit                done_after, busy_seen, valid_after_clr, done_after_clr, busy_after_clr;

  // Runs one pass and records beats; optional clr once clr_at beats were taken.
  task automatic run_pass(input logic [11:0] c, input logic [9:0] h, input int rdy_pct,
                          input int clr_at, input bit poke_start);
    int budget;
    got_data.delete(); got_last.delete(); got_addr.delete();
    done_cnt = 0; first_valid = -1; max_cnt = 0; busy_seen = 0;
    budget = 40 * (int'(c) >> 2) * int'(h) + 50;
    bus.shape = {c, h, 10'd7};
    bus.start = 1'b1;
    for (int cyc = 0; cyc < budget; cyc++) begin
      @(negedge clk);
      bus.start = poke_start && (cyc == 2);
      if (bus.busy) busy_seen = 1;
      if (cyc < 16) got_addr.push_back(bus.rdaddr);
      if (int'(dut.u_fifo.cnt_q) > max_cnt) max_cnt = int'(dut.u_fifo.cnt_q);
      if (bus.done) begin done_cnt++; break; end
      if (bus.m_valid && first_valid < 0) first_valid = cyc;
      bus.m_ready = ($urandom_range(99) < rdy_pct);
      if (clr_at >= 0 && got_data.size() == clr_at && bus.m_valid) begin
        bus.clr = 1'b1;
        @(negedge clk);
        bus.clr = 1'b0;
        valid_after_clr = bus.m_valid;
        done_after_clr  = bus.done;
        busy_after_clr  = bus.busy;
        break;
      end
      if (bus.m_valid && bus.m_ready) begin
        got_data.push_back(bus.m_data);
        got_last.push_back(bus.m_last);
      end
    end
    bus.start = 1'b0;
    @(negedge clk);
    done_after  = bus.done;
    bus.m_ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    n_checks++; if (bus.rdaddr !== '0) begin n_fail++; $display("FAIL reset_rdaddr: got %0h exp 0", bus.rdaddr); end
    n_checks++; if (bus.m_valid !== 1'b0) begin n_fail++; $display("FAIL reset_m_valid: got %0b exp 0", bus.m_valid); end
    n_checks++; if (bus.m_data !== '0) begin n_fail++; $display("FAIL reset_m_data: got %0h exp 0", bus.m_data); end
    n_checks++; if (bus.m_last !== 1'b0) begin n_fail++; $display("FAIL reset_m_last: got %0b exp 0", bus.m_last); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b exp 0", bus.busy); end
    n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %0b exp 0", bus.done); end
  endtask

  task automatic test_basic();
    int len = model_len(8, 3);
    run_pass(12'd8, 10'd3, 100, -1, 1'b0);
    n_checks++; if (first_valid !== 2) begin n_fail++; $display("FAIL basic_latency: got %0d exp 2", first_valid); end
    n_checks++; if (busy_seen !== 1'b1) begin n_fail++; $display("FAIL basic_busy: got %0b exp 1", busy_seen); end
    n_checks++; if (done_cnt !== 1) begin n_fail++; $display("FAIL basic_done: got %0d exp 1", done_cnt); end
    n_checks++; if (done_after !== 1'b0) begin n_fail++; $display("FAIL basic_done_width: got %0b exp 0", done_after); end
    n_checks++; if (got_data.size() !== len) begin n_fail++; $display("FAIL basic_beats: got %0d exp %0d", got_data.size(), len); end
    for (int k = 0; k < got_data.size(); k++) begin
      n_checks++; if (got_data[k] !== exp_row(k)) begin n_fail++; $display("FAIL basic_data[%0d]: got %h exp %h", k, got_data[k], exp_row(k)); end
      n_checks++; if (got_last[k] !== (k == len - 1)) begin n_fail++; $display("FAIL basic_last[%0d]: got %0b exp %0b", k, got_last[k], k == len - 1); end
    end
    for (int k = 0; k < len; k++) begin
      n_checks++; if (got_addr[k] !== exp_addr(k)) begin n_fail++; $display("FAIL basic_addr[%0d]: got %h exp %h", k, got_addr[k], exp_addr(k)); end
    end
    model_advance(len);
  endtask

  task automatic test_rotation();
    int len = model_len(8, 3);
    logic [AW*N-1:0] six = {N{9'd6}};
    for (int p = 0; p < 5; p++) begin
      run_pass(12'd8, 10'd3, 100, -1, 1'b0);
      n_checks++; if (got_data.size() !== len) begin n_fail++; $display("FAIL rot_beats p%0d: got %0d exp %0d", p, got_data.size(), len); end
      for (int k = 0; k < got_data.size(); k++) begin
        n_checks++; if (got_data[k] !== exp_row(k)) begin n_fail++; $display("FAIL rot_data p%0d[%0d]: got %h exp %h", p, k, got_data[k], exp_row(k)); end
      end
      for (int k = 0; k < len; k++) begin
        n_checks++; if (got_addr[k] !== exp_addr(k)) begin n_fail++; $display("FAIL rot_addr p%0d[%0d]: got %h exp %h", p, k, got_addr[k], exp_addr(k)); end
      end
      // Fifth pass of the basic+4 sequence starts with every base at 6 and rot back at 0.
      if (p == 4) begin
        n_checks++; if (got_addr[0] !== six) begin n_fail++; $display("FAIL rot_all_bases_6: got %h exp %h", got_addr[0], six); end
      end
      model_advance(len);
    end
  endtask

  task automatic test_random_ready();
    int c, h, len;
    for (int p = 0; p < 6; p++) begin
      c = int'($urandom_range(40, 4));
      h = int'($urandom_range(6, 1));
      len = model_len(c, h);
      run_pass(12'(c), 10'(h), 30, -1, 1'b0);
      n_checks++; if (done_cnt !== 1) begin n_fail++; $display("FAIL rnd_done p%0d: got %0d exp 1", p, done_cnt); end
      n_checks++; if (got_data.size() !== len) begin n_fail++; $display("FAIL rnd_beats p%0d: got %0d exp %0d", p, got_data.size(), len); end
      n_checks++; if (max_cnt > 4) begin n_fail++; $display("FAIL rnd_fifo_level p%0d: got %0d exp <=4", p, max_cnt); end
      for (int k = 0; k < got_data.size(); k++) begin
        n_checks++; if (got_data[k] !== exp_row(k)) begin n_fail++; $display("FAIL rnd_data p%0d[%0d]: got %h exp %h", p, k, got_data[k], exp_row(k)); end
        n_checks++; if (got_last[k] !== (k == len - 1)) begin n_fail++; $display("FAIL rnd_last p%0d[%0d]: got %0b exp %0b", p, k, got_last[k], k == len - 1); end
      end
      model_advance(len);
    end
  endtask

  task automatic test_clr();
    int len = model_len(8, 3);
    run_pass(12'd8, 10'd5, 100, 3, 1'b0);
    n_checks++; if (got_data.size() !== 3) begin n_fail++; $display("FAIL clr_beats: got %0d exp 3", got_data.size()); end
    for (int k = 0; k < got_data.size(); k++) begin
      n_checks++; if (got_data[k] !== exp_row(k)) begin n_fail++; $display("FAIL clr_data[%0d]: got %h exp %h", k, got_data[k], exp_row(k)); end
    end
    n_checks++; if (valid_after_clr !== 1'b0) begin n_fail++; $display("FAIL clr_m_valid: got %0b exp 0", valid_after_clr); end
    n_checks++; if (busy_after_clr !== 1'b0) begin n_fail++; $display("FAIL clr_busy: got %0b exp 0", busy_after_clr); end
    n_checks++; if ((done_after_clr | done_after) !== 1'b0 || done_cnt !== 0) begin
      n_fail++; $display("FAIL clr_no_done: got %0b/%0b/%0d exp 0/0/0", done_after_clr, done_after, done_cnt);
    end
    model_reset();
    run_pass(12'd8, 10'd3, 100, -1, 1'b0);
    n_checks++; if (got_data.size() !== len) begin n_fail++; $display("FAIL clr_restart_beats: got %0d exp %0d", got_data.size(), len); end
    for (int k = 0; k < got_data.size(); k++) begin
      n_checks++; if (got_data[k] !== exp_row(k)) begin n_fail++; $display("FAIL clr_restart_data[%0d]: got %h exp %h", k, got_data[k], exp_row(k)); end
    end
    for (int k = 0; k < len; k++) begin
      n_checks++; if (got_addr[k] !== exp_addr(k)) begin n_fail++; $display("FAIL clr_restart_addr[%0d]: got %h exp %h", k, got_addr[k], exp_addr(k)); end
    end
    model_advance(len);
  endtask

  task automatic test_wrap();
    int len;
    logic [AW-1:0] a1, a2;
    bus.clr = 1'b1;
    @(negedge clk);
    bus.clr = 1'b0;
    model_reset();
    len = model_len(1020, 2);
    run_pass(12'd1020, 10'd2, 100, -1, 1'b0);
    n_checks++; if (got_data.size() !== len) begin n_fail++; $display("FAIL wrap_long_beats: got %0d exp %0d", got_data.size(), len); end
    for (int k = 0; k < got_data.size(); k++) begin
      n_checks++; if (got_data[k] !== exp_row(k)) begin n_fail++; $display("FAIL wrap_long_data[%0d]: got %h exp %h", k, got_data[k], exp_row(k)); end
    end
    model_advance(len);
    for (int p = 0; p < 4; p++) begin
      run_pass(12'd0, 10'd5, 100, -1, 1'b0);
      n_checks++; if (done_cnt !== 1 || got_data.size() !== 0) begin
        n_fail++; $display("FAIL wrap_skip p%0d: got done %0d beats %0d exp 1/0", p, done_cnt, got_data.size());
      end
      model_advance(0);
    end
    len = model_len(8, 3);
    run_pass(12'd8, 10'd3, 100, -1, 1'b0);
    for (int k = 0; k < len; k++) begin
      n_checks++; if (got_addr[k] !== exp_addr(k)) begin n_fail++; $display("FAIL wrap_addr[%0d]: got %h exp %h", k, got_addr[k], exp_addr(k)); end
    end
    a1 = got_addr[1][AW-1:0];
    a2 = got_addr[2][AW-1:0];
    n_checks++; if (a1 !== 9'd511 || a2 !== 9'd0) begin n_fail++; $display("FAIL wrap_bank0: got %0d,%0d exp 511,0", a1, a2); end
    for (int k = 0; k < got_data.size(); k++) begin
      n_checks++; if (got_data[k] !== exp_row(k)) begin n_fail++; $display("FAIL wrap_data[%0d]: got %h exp %h", k, got_data[k], exp_row(k)); end
    end
    model_advance(len);
  endtask

  task automatic test_zero_len();
    int cs [3] = '{0, 3, 2048};
    int hs [3] = '{7, 9, 1};
    for (int p = 0; p < 3; p++) begin
      run_pass(12'(cs[p]), 10'(hs[p]), 100, -1, 1'b0);
      n_checks++; if (done_cnt !== 1) begin n_fail++; $display("FAIL zero_done p%0d: got %0d exp 1", p, done_cnt); end
      n_checks++; if (got_data.size() !== 0) begin n_fail++; $display("FAIL zero_beats p%0d: got %0d exp 0", p, got_data.size()); end
      model_advance(0);
    end
  endtask

  task automatic test_busy_start();
    int len = model_len(12, 4);
    run_pass(12'd12, 10'd4, 100, -1, 1'b1);
    n_checks++; if (got_data.size() !== len) begin n_fail++; $display("FAIL busy_start_beats: got %0d exp %0d", got_data.size(), len); end
    for (int k = 0; k < got_data.size(); k++) begin
      n_checks++; if (got_data[k] !== exp_row(k)) begin n_fail++; $display("FAIL busy_start_data[%0d]: got %h exp %h", k, got_data[k], exp_row(k)); end
    end
    model_advance(len);
    repeat (4) @(negedge clk);
    n_checks++; if (bus.busy !== 1'b0 || bus.m_valid !== 1'b0) begin
      n_fail++; $display("FAIL busy_start_idle: got busy %0b valid %0b exp 0/0", bus.busy, bus.m_valid);
    end
    len = model_len(8, 3);
    run_pass(12'd8, 10'd3, 100, -1, 1'b0);
    for (int k = 0; k < got_data.size(); k++) begin
      n_checks++; if (got_data[k] !== exp_row(k)) begin n_fail++; $display("FAIL busy_after_data[%0d]: got %h exp %h", k, got_data[k], exp_row(k)); end
    end
    model_advance(len);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rstn      = 1'b0;
    bus.start = 1'b0;
    bus.clr   = 1'b0;
    bus.m_ready = 1'b0;
    bus.shape = '0;
    model_reset();
    test_reset();
    test_basic();
    test_rotation();
    test_random_ready();
    test_clr();
    test_wrap();
    test_zero_len();
    test_busy_start();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
